// File: rtl/operand_fetch_if.sv
// Handshake and register-file write bus for the operand fetch stage.
// The master drives instructions, writes and out_ready; the slave (the stage) returns operands.
interface operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] srca;
    logic [31:0] shift_in;
    logic [6:0]  shift_ctl;

    modport master (
        output in_valid, instr, pc, we, wa, wd, out_ready,
        input  in_ready, out_valid, srca, shift_in, shift_ctl
    );

    modport slave (
        input  in_valid, instr, pc, we, wa, wd, out_ready,
        output in_ready, out_valid, srca, shift_in, shift_ctl
    );
endinterface

// File: rtl/operand_fetch.sv
// ARM data-processing operand fetch: R0-R14 register file, R15 = pc + PC_OFFSET, one-deep output register.
// Define OPERAND_FETCH_REG_SHIFT_EN to take the shift amount from Rs (instr[11:8]) when instr[4]=1.
module operand_fetch #(
    parameter logic [31:0] PC_OFFSET = 32'd8
) (
    input logic            clk,
    input logic            rst_n,
    operand_fetch_if.slave bus
);

    logic [31:0] rf [0:14];
    logic [31:0] rd_view [0:15];
    logic        wr_en;

    logic [31:0] srca_p0;
    logic [31:0] shift_in_p0;
    logic [6:0]  shift_ctl_p0;
    logic        accept_p0;

    logic [31:0] srca_p1;
    logic [31:0] shift_in_p1;
    logic [6:0]  shift_ctl_p1;
    logic        vld_p1;

    assign wr_en = bus.we && (bus.wa != 4'd15);

    // Every read port sees this view: same-cycle writes bypass, R15 is the pipelined pc.
    always_comb begin
        for (int i = 0; i < 15; i++) begin
            rd_view[i] = (wr_en && (bus.wa == 4'(i))) ? bus.wd : rf[i];
        end
        rd_view[15] = bus.pc + PC_OFFSET;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (wr_en && (bus.wa == 4'(i))) begin
                    rf[i] <= bus.wd;
                end
            end
        end
    end

    // ---- stage p0: operand decode ----
    always_comb begin
        srca_p0 = rd_view[bus.instr[19:16]];
        if (bus.instr[25]) begin
            shift_in_p0  = {24'b0, bus.instr[7:0]};
            shift_ctl_p0 = {bus.instr[11:8], 1'b0, 2'b11};
        end else begin
            shift_in_p0  = rd_view[bus.instr[3:0]];
            shift_ctl_p0 = {bus.instr[11:7], bus.instr[6:5]};
`ifdef OPERAND_FETCH_REG_SHIFT_EN
            if (bus.instr[4]) begin
                shift_ctl_p0 = {rd_view[bus.instr[11:8]][4:0], bus.instr[6:5]};
            end
`endif
        end
    end

    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign accept_p0    = bus.in_valid && bus.in_ready;

    // ---- stage p1: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            srca_p1      <= '0;
            shift_in_p1  <= '0;
            shift_ctl_p1 <= '0;
        end else if (accept_p0) begin
            vld_p1       <= 1'b1;
            srca_p1      <= srca_p0;
            shift_in_p1  <= shift_in_p0;
            shift_ctl_p1 <= shift_ctl_p0;
        end else if (bus.out_ready) begin
            vld_p1       <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.srca      = srca_p1;
    assign bus.shift_in  = shift_in_p1;
    assign bus.shift_ctl = shift_ctl_p1;

endmodule
